// File: rtl/fft_pkg.sv
// fft_pkg: FSM states, control-word bit positions, sizing and bank selects for the FFT sequencer.
package fft_pkg;
  localparam int NUM_ROWS = 8;
  localparam int NUM_PASS = 2;
  localparam int PIPE_LAT = 4;
  localparam int NUM_STAGE = 3;
  localparam int NUM_BFLY = 4;
  localparam int CS_W = 15;
  localparam int CS_MEMWR = 14;
  localparam int CS_RDMEM = 13;
  localparam int CS_RS1 = 10;
  localparam int CS_RS2 = 7;
  localparam int CS_IN_SEL = 6;
  localparam int CS_DEST_SEL = 5;
  localparam int CS_K = 0;
  localparam logic IN_SEL_BANK1 = 1'b0;
  localparam logic IN_SEL_BANK2 = 1'b1;
  localparam logic DEST_BANK2 = 1'b1;
  localparam logic DEST_INPLACE = 1'b0;
  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT, STORE, HOLD, DONE} state_t;
  // Lower operand of butterfly j in stage s: span h = 4>>s.
  function automatic logic [2:0] bfly_lower(input logic [1:0] s, input logic [1:0] j);
    int h;
    h = 4 >> s;
    return 3'((int'(j) / h) * 2 * h + int'(j) % h);
  endfunction
endpackage

// File: rtl/fft_twiddle_idx.sv
// fft_twiddle_idx: twiddle exponent k (W64^k) for a butterfly from pass, row, stage and lower index.
module fft_twiddle_idx
  import fft_pkg::*;
(
  input  logic       pass,
  input  logic [2:0] row,
  input  logic [1:0] stage,
  input  logic [2:0] p,
  output logic [4:0] k
);
  int n, h;
  always_comb begin
    n = int'(row) + NUM_ROWS * int'(p);
    h = 4 >> stage;
    k = pass ? 5'(((int'(p) % h) << (stage + 3)) % 32) : 5'(((n % (32 >> stage)) << stage) % 32);
  end
endmodule

// File: rtl/fft_sequencer.sv
// fft_sequencer: control-word sequencer for the 2-pass x 8-row 64-point FFT datapath.
// FFT_SEQ_HOLD_EN adds the hold port, parking the FSM in HOLD between a STORE and the next LOAD.
module fft_sequencer
  import fft_pkg::*;
(
  input  logic            clk,
  input  logic            reset_n,
  input  logic            en_fft,
`ifdef FFT_SEQ_HOLD_EN
  input  logic            hold,
`endif
  output logic [CS_W-1:0] controlsignal,
  output logic            done_fft
);
  state_t state, n_state;
  logic pass, n_pass;
  logic [2:0] row, n_row;
  logic [1:0] stage, n_stage;
  logic [2:0] cnt, n_cnt;
  logic [2:0] p;
  logic [4:0] k;
  logic hold_req, last_row;
  logic [CS_W-1:0] n_cs;
`ifdef FFT_SEQ_HOLD_EN
  assign hold_req = hold;
`else
  assign hold_req = 1'b0;
`endif
  assign last_row = row == 3'(NUM_ROWS - 1) && pass == 1'(NUM_PASS - 1);
  always_comb begin
    n_state = state;
    n_pass = pass;
    n_row = row;
    n_stage = stage;
    n_cnt = cnt;
    case (state)
      IDLE: n_state = en_fft ? LOAD : IDLE;
      LOAD: begin
        n_state = ISSUE;
        n_stage = '0;
        n_cnt = '0;
      end
      ISSUE: begin
        n_state = cnt == 3'(NUM_BFLY - 1) ? WAIT : ISSUE;
        n_cnt = cnt == 3'(NUM_BFLY - 1) ? '0 : cnt + 3'd1;
      end
      WAIT: begin
        n_cnt = cnt == 3'(PIPE_LAT - 1) ? '0 : cnt + 3'd1;
        n_state = cnt != 3'(PIPE_LAT - 1) ? WAIT : stage == 2'(NUM_STAGE - 1) ? STORE : ISSUE;
        n_stage = cnt == 3'(PIPE_LAT - 1) && stage != 2'(NUM_STAGE - 1) ? stage + 2'd1 : stage;
      end
      STORE: begin
        n_state = last_row ? DONE : hold_req ? HOLD : LOAD;
        n_row = row + 3'd1;
        n_pass = row == 3'(NUM_ROWS - 1) ? ~pass : pass;
      end
      HOLD: n_state = hold_req ? HOLD : LOAD;
      DONE: n_state = IDLE;
      default: n_state = IDLE;
    endcase
  end
  // Control word is computed for the state being entered so it can be registered.
  assign p = bfly_lower(n_stage, n_cnt[1:0]);
  fft_twiddle_idx u_twiddle (
    .pass (n_pass),
    .row  (n_row),
    .stage(n_stage),
    .p    (p),
    .k    (k)
  );
  always_comb begin
    n_cs = '0;
    case (n_state)
      LOAD: n_cs[CS_RDMEM] = 1'b1;
      ISSUE: begin
        n_cs[CS_RS1+:3] = p;
        n_cs[CS_RS2+:3] = p + 3'(4 >> n_stage);
        n_cs[CS_IN_SEL] = n_stage == 2'd0 ? IN_SEL_BANK1 : IN_SEL_BANK2;
        n_cs[CS_DEST_SEL] = n_stage == 2'd0 ? DEST_BANK2 : DEST_INPLACE;
        n_cs[CS_K+:5] = k;
      end
      WAIT: n_cs = controlsignal;
      STORE: begin
        n_cs = controlsignal;
        n_cs[CS_MEMWR] = 1'b1;
      end
      default: n_cs = '0;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= IDLE;
      pass <= 1'b0;
      row <= '0;
      stage <= '0;
      cnt <= '0;
      controlsignal <= '0;
      done_fft <= 1'b0;
    end else begin
      state <= n_state;
      pass <= n_pass;
      row <= n_row;
      stage <= n_stage;
      cnt <= n_cnt;
      controlsignal <= n_cs;
      done_fft <= n_state == DONE;
    end
endmodule

// File: tb/tb_fft_sequencer.sv
// tb_fft_sequencer: trace-based model of a full FFT run checked against the sequencer every cycle.
module tb_fft_sequencer;
`ifdef FFT_SEQ_HOLD_EN
  localparam bit HOLD_EN = 1'b1;
`else
  localparam bit HOLD_EN = 1'b0;
`endif
  logic clk = 1'b0, reset_n = 1'b0, en_fft = 1'b0, hold = 1'b0;
  logic [14:0] controlsignal;
  logic done_fft;
  int checks = 0, failures = 0;
  logic [14:0] tr [416];
  int mc = 0;
  logic mh = 1'b0;
  int n_load = 0, n_store = 0, n_done = 0;

  always #5 clk = ~clk;

  fft_sequencer dut (
    .clk(clk),
    .reset_n(reset_n),
    .en_fft(en_fft),
`ifdef FFT_SEQ_HOLD_EN
    .hold(hold),
`endif
    .controlsignal(controlsignal),
    .done_fft(done_fft)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (model idx %0d)", name, act, exp, mc);
    end
  endtask

  // Expected control word for each of the 416 busy cycles, straight from the pairing/twiddle rules.
  task automatic build_trace();
    int i;
    logic [14:0] w;
    i = 0;
    w = '0;
    for (int ps = 0; ps < 2; ps++)
      for (int r = 0; r < 8; r++) begin
        tr[i] = 15'h2000;
        i = i + 1;
        for (int s = 0; s < 3; s++) begin
          int h;
          h = 4 >> s;
          for (int j = 0; j < 4; j++) begin
            int p, k;
            p = (j / h) * 2 * h + j % h;
            k = ps == 0 ? (((r + 8 * p) % (32 >> s)) << s) % 32 : ((p % h) << (s + 3)) % 32;
            w = 15'((p << 10) | ((p + h) << 7) | ((s == 0 ? 0 : 1) << 6) | ((s == 0 ? 1 : 0) << 5) | k);
            tr[i] = w;
            i = i + 1;
          end
          for (int d = 0; d < 4; d++) begin
            tr[i] = w;
            i = i + 1;
          end
        end
        tr[i] = w | 15'h4000;
        i = i + 1;
      end
  endtask

  // mc: 0 idle, 1..416 busy (trace index mc-1), 417 done cycle; mh: parked between rows.
  always @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      mc <= 0;
      mh <= 1'b0;
    end else if (mh) begin
      if (!hold) begin
        mh <= 1'b0;
        mc <= mc + 1;
      end
    end else if (mc == 0) begin
      if (en_fft) mc <= 1;
    end else if (mc == 417) mc <= 0;
    else if (tr[mc-1][14] && mc != 416 && HOLD_EN && hold) mh <= 1'b1;
    else mc <= mc + 1;

  function automatic logic [14:0] exp_cs();
    if (mh || mc == 0 || mc == 417) return '0;
    return tr[mc-1];
  endfunction

  initial forever begin
    @(posedge clk);
    #2;
    chk("cs_trace", 32'(controlsignal), 32'(exp_cs()));
    chk("done_trace", 32'(done_fft), 32'(mc == 417));
    chk("rd_wr_exclusive", 32'(controlsignal[13] & controlsignal[14]), 0);
    n_load += 32'(controlsignal[13]);
    n_store += 32'(controlsignal[14]);
    n_done += 32'(done_fft);
  end

  task automatic run_fft(input int abort_at, input bit busy, input bit hold_test, output int lat);
    int n, l0, s0, d0;
    n = 0;
    l0 = n_load;
    s0 = n_store;
    d0 = n_done;
    @(negedge clk);
    en_fft = 1'b1;
    @(negedge clk);
    en_fft = 1'b0;
    chk("load_after_en", 32'(controlsignal[13]), 1);
    while (!done_fft && n < 1000) begin
      if (n == abort_at) begin
        reset_n = 1'b0;
        #1;
        chk("abort_cs", 32'(controlsignal), 0);
        chk("abort_done", 32'(done_fft), 0);
        @(negedge clk);
        reset_n = 1'b1;
        lat = n;
        return;
      end
      en_fft = busy && (n == 50 || n == 200 || n == 300);
      hold = hold_test && n >= 103 && n < 113;
      @(negedge clk);
      n++;
    end
    lat = n;
    hold = 1'b0;
    en_fft = busy;
    @(negedge clk);
    en_fft = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_after_done", 32'(controlsignal), 0);
    chk("load_count", 32'(n_load - l0), 16);
    chk("store_count", 32'(n_store - s0), 16);
    chk("done_count", 32'(n_done - d0), 1);
  endtask

  initial begin
    int lat;
    build_trace();
    chk("model_load", 32'(tr[0]), 32'h2000);
    chk("model_p0r0s0_j0", 32'(tr[1]), 32'h0220);
    chk("model_p0r0s0_j1", 32'(tr[2]), 32'h06A8);
    chk("model_p0r0s0_j2", 32'(tr[3]), 32'h0B30);
    chk("model_p0r0s0_j3", 32'(tr[4]), 32'h0FB8);
    chk("model_wait_hold", 32'(tr[8]), 32'h0FB8);
    chk("model_store", 32'(tr[25]), 32'h5BC0);
    chk("model_p0r1s0_j1", 32'(tr[28]), 32'h06A9);
    chk("model_p1r0s1_j1", 32'(tr[218]), 32'h05D0);
    chk("model_p1s2_j0", 32'(tr[225]), 32'h00C0);
    chk("model_p1s2_j1", 32'(tr[226]), 32'h09C0);
    chk("model_p1s2_j2", 32'(tr[227]), 32'h12C0);
    chk("model_p1s2_j3", 32'(tr[228]), 32'h1BC0);
    chk("model_p1s2_wait", 32'(tr[232]), 32'h1BC0);
    #3;
    chk("reset_cs", 32'(controlsignal), 0);
    chk("reset_done", 32'(done_fft), 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_cs", 32'(controlsignal), 0);
    run_fft(20, 1'b0, 1'b0, lat);
    repeat (5) @(negedge clk);
    chk("idle_after_abort", 32'(controlsignal), 0);
    run_fft(-1, 1'b0, 1'b0, lat);
    chk("latency", 32'(lat), 416);
    run_fft(-1, 1'b1, 1'b0, lat);
    chk("latency_busy_pulses", 32'(lat), 416);
`ifdef FFT_SEQ_HOLD_EN
    run_fft(-1, 1'b0, 1'b1, lat);
    chk("latency_hold", 32'(lat), 426);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
